strob_wr_gen: RTL and testbench

- Initiator side of the write-strobe interface: turns a one-cycle internal write request plus data into a stretched `strob_WR` pulse with a stable data bus.
- The target samples `strob_WR` through a two-flop chain and edge-detects it into a one-cycle `strob_main`.
- Guarantees data setup and hold around the strobe, and a minimum low gap between strobes, so the far side never misses or double-counts an edge.

---
 rtl/strob_wr_gen.sv | 211 +++++++++++++++++++++
 tb/tb_strob_wr_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/strob_wr_gen.sv
// Write-strobe initiator: stretches a one-cycle request into a setup/strobe/hold/gap sequence.
// Define STROB_WR_ACK_EN to add a 4-phase ack handshake with timeout.
module strob_wr_gen #(
    parameter int DATA_W      = 8,
    parameter int SETUP_CYC   = 1,
    parameter int HIGH_CYC    = 3,
    parameter int HOLD_CYC    = 1,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              CLK,
    input  logic              CLR_n,
    input  logic              req_in,
    input  logic [DATA_W-1:0] data_in,
`ifdef STROB_WR_ACK_EN
    input  logic              ack_in,
    output logic              timeout_err,
`endif
    output logic              busy,
    output logic              done,
    output logic              req_drop,
    output logic [DATA_W-1:0] data_out,
    output logic              strob_WR
);

    localparam int MAX_SH = (SETUP_CYC > HIGH_CYC) ? SETUP_CYC : HIGH_CYC;
    localparam int MAX_HG = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int MAX_P  = (MAX_SH > MAX_HG) ? MAX_SH : MAX_HG;
    localparam int CNT_W  = $clog2(MAX_P + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_STROBE  = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;

    if (SETUP_CYC < 1) begin : g_bad_setup
        $fatal(1, "strob_wr_gen: SETUP_CYC must be >= 1");
    end
    if (HIGH_CYC < 3) begin : g_bad_high
        $fatal(1, "strob_wr_gen: HIGH_CYC must be >= 3");
    end
    if (HOLD_CYC < 1) begin : g_bad_hold
        $fatal(1, "strob_wr_gen: HOLD_CYC must be >= 1");
    end
    if (GAP_CYC < 2) begin : g_bad_gap
        $fatal(1, "strob_wr_gen: GAP_CYC must be >= 2");
    end

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              strob_q, strob_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;
    logic              cntZero;
    logic              ackOk;
    logic              relOk;

    assign cntZero = (cnt_q == '0);

`ifdef STROB_WR_ACK_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $fatal(1, "strob_wr_gen: TIMEOUT_CYC must be >= 1");
    end

    logic             ackMeta_q;
    logic             ackS_q;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmoSeen_q, tmoSeen_d;
    logic             timeoutErr_q, timeoutErr_d;
    logic             tmoHit;
    logic             waitState;

    // The timeout counter saturates at expiry so a late ack cannot re-arm it.
    assign tmoHit    = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
    assign waitState = (state_q == S_STROBE) || (state_q == S_RECOVER);
    assign ackOk     = ackS_q || tmoHit;
    assign relOk     = !ackS_q || tmoHit;

    always_comb begin
        tmo_d        = tmo_q;
        tmoSeen_d    = tmoSeen_q;
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (waitState && !tmoHit) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        if (state_q == S_IDLE && req_in) begin
            tmoSeen_d = 1'b0;
        end else if (state_q == S_STROBE && state_d == S_HOLD && !ackS_q) begin
            tmoSeen_d = 1'b1;
        end else if (state_q == S_RECOVER && state_d == S_IDLE && ackS_q) begin
            tmoSeen_d = 1'b1;
        end
        timeoutErr_d = done_d && tmoSeen_d;
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            ackMeta_q    <= 1'b0;
            ackS_q       <= 1'b0;
            tmo_q        <= '0;
            tmoSeen_q    <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            ackMeta_q    <= ack_in;
            ackS_q       <= ackMeta_q;
            tmo_q        <= tmo_d;
            tmoSeen_q    <= tmoSeen_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    assign timeout_err = timeoutErr_q;
`else
    assign ackOk = 1'b1;
    assign relOk = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        busy_d  = busy_q;
        strob_d = strob_q;
        done_d  = 1'b0;
        drop_d  = req_in && busy_q;
        case (state_q)
            S_IDLE: begin
                if (req_in) begin
                    state_d = S_SETUP;
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                    data_d  = data_in;
                    busy_d  = 1'b1;
                end
            end
            S_SETUP: begin
                if (cntZero) begin
                    state_d = S_STROBE;
                    cnt_d   = CNT_W'(HIGH_CYC - 1);
                    strob_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STROBE: begin
                if (cntZero && ackOk) begin
                    state_d = S_HOLD;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                    strob_d = 1'b0;
                end else if (!cntZero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cntZero) begin
                    state_d = S_RECOVER;
                    cnt_d   = CNT_W'(GAP_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RECOVER: begin
                if (cntZero && relOk) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (!cntZero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
                strob_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            strob_q <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            strob_q <= strob_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign req_drop = drop_q;
    assign data_out = data_q;
    assign strob_WR = strob_q;

endmodule

// File: tb/tb_strob_wr_gen.sv
// Scoreboard bench for strob_wr_gen: two instances (default timing and a stretched set)
// share one random request stream and are checked against a per-transaction timing model.
module tb_strob_wr_gen;

    typedef struct {
        logic [7:0] data;
        int         rise;
        int         fall;
        int         doneAt;
    } txn_t;

    logic       CLK = 1'b0;
    logic       CLR_n = 1'b0;
    logic       reqIn = 1'b0;
    logic [7:0] dataIn = 8'h00;

    logic       busyA, doneA, dropA, strobA;
    logic [7:0] dataA;
    logic       busyB, doneB, dropB, strobB;
    logic [7:0] dataB;

    strob_wr_gen #(.DATA_W(8), .SETUP_CYC(1), .HIGH_CYC(3), .HOLD_CYC(1), .GAP_CYC(2), .TIMEOUT_CYC(64)) dutA (
        .CLK(CLK), .CLR_n(CLR_n), .req_in(reqIn), .data_in(dataIn),
        .busy(busyA), .done(doneA), .req_drop(dropA), .data_out(dataA), .strob_WR(strobA)
    );

    strob_wr_gen #(.DATA_W(8), .SETUP_CYC(2), .HIGH_CYC(5), .HOLD_CYC(2), .GAP_CYC(3), .TIMEOUT_CYC(64)) dutB (
        .CLK(CLK), .CLR_n(CLR_n), .req_in(reqIn), .data_in(dataIn),
        .busy(busyB), .done(doneB), .req_drop(dropB), .data_out(dataB), .strob_WR(strobB)
    );

    always #5 CLK = ~CLK;

    int edgeCnt = 0;
    always @(posedge CLK) edgeCnt <= edgeCnt + 1;

    int sCyc[2]  = '{1, 2};
    int hCyc[2]  = '{3, 5};
    int hoCyc[2] = '{1, 2};
    int gCyc[2]  = '{2, 3};

    // Reference model: one transfer in flight per instance, timing computed from the cycle counts.
    int         lastAcc[2];
    int         lastDone[2];
    logic [7:0] lastData[2];
    logic [7:0] prevData[2];
    txn_t       expQ0[$];
    txn_t       expQ1[$];
    int         dropQ0[$];
    int         dropQ1[$];

    logic       prevStrob[2];
    int         obsRise[2];
    int         obsFall[2];
    int         prevFall[2];
    int         riseCount[2];
    logic [7:0] obsData[2];

    int checks = 0;
    int fails = 0;

    task automatic checkOutput(input string name, input int inst, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s (dut%0d) at edge %0d: got %0d, expected %0d", name, inst, edgeCnt, actual, expected);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 2; i++) begin
            lastAcc[i]   = edgeCnt;
            lastDone[i]  = edgeCnt;
            lastData[i]  = 8'h00;
            prevData[i]  = 8'h00;
            prevStrob[i] = 1'b0;
            obsRise[i]   = -1;
            obsFall[i]   = -1;
            prevFall[i]  = -1;
            riseCount[i] = 0;
            obsData[i]   = 8'h00;
        end
        expQ0.delete();
        expQ1.delete();
        dropQ0.delete();
        dropQ1.delete();
    endtask

    task automatic modelRequest(input int e, input logic [7:0] d);
        txn_t t;
        for (int i = 0; i < 2; i++) begin
            if (e > lastDone[i]) begin
                t.data      = d;
                t.rise      = e + sCyc[i];
                t.fall      = t.rise + hCyc[i];
                t.doneAt    = t.fall + hoCyc[i] + gCyc[i];
                prevData[i] = lastData[i];
                lastData[i] = d;
                lastAcc[i]  = e;
                lastDone[i] = t.doneAt;
                if (i == 0) expQ0.push_back(t);
                else        expQ1.push_back(t);
            end else begin
                if (i == 0) dropQ0.push_back(e);
                else        dropQ1.push_back(e);
            end
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [7:0] d);
        @(posedge CLK);
        #1;
        reqIn  = req;
        dataIn = d;
        if (req) modelRequest(edgeCnt + 1, d);
    endtask

    task automatic monitorStep(input int i, input logic strob, input logic busy,
                               input logic done, input logic drop, input logic [7:0] data);
        int   k;
        txn_t t;
        int   de;
        logic have;
        k = edgeCnt;
        checkOutput("busy", i, int'(busy), int'(k >= lastAcc[i] && k < lastDone[i]));
        checkOutput("data_out", i, int'(data), int'((k >= lastAcc[i]) ? lastData[i] : prevData[i]));
        if (strob && !prevStrob[i]) begin
            obsRise[i] = k;
            obsData[i] = data;
            riseCount[i]++;
            if (prevFall[i] >= 0)
                checkOutput("strob_low_gap_ok", i, int'((k - prevFall[i]) >= (hoCyc[i] + gCyc[i] + sCyc[i])), 1);
        end
        if (!strob && prevStrob[i]) begin
            obsFall[i]  = k;
            prevFall[i] = k;
        end
        prevStrob[i] = strob;
        if (drop) begin
            have = (i == 0) ? (dropQ0.size() > 0) : (dropQ1.size() > 0);
            if (!have) begin
                checkOutput("req_drop_unexpected", i, 1, 0);
            end else begin
                de = (i == 0) ? dropQ0.pop_front() : dropQ1.pop_front();
                checkOutput("req_drop_edge", i, k, de);
            end
        end
        if (done) begin
            have = (i == 0) ? (expQ0.size() > 0) : (expQ1.size() > 0);
            if (!have) begin
                checkOutput("done_unexpected", i, 1, 0);
            end else begin
                t = (i == 0) ? expQ0.pop_front() : expQ1.pop_front();
                checkOutput("done_edge", i, k, t.doneAt);
                checkOutput("strob_rise_edge", i, obsRise[i], t.rise);
                checkOutput("strob_fall_edge", i, obsFall[i], t.fall);
                checkOutput("data_at_strobe", i, int'(obsData[i]), int'(t.data));
                checkOutput("strobes_per_txn", i, riseCount[i], 1);
            end
            riseCount[i] = 0;
        end
    endtask

    always @(negedge CLK) begin
        if (CLR_n) begin
            monitorStep(0, strobA, busyA, doneA, dropA, dataA);
            monitorStep(1, strobB, busyB, doneB, dropB, dataB);
        end
    end

    initial begin
        resetModel();
        #3;
        checkOutput("reset_busy", 0, int'(busyA), 0);
        checkOutput("reset_done", 0, int'(doneA), 0);
        checkOutput("reset_req_drop", 0, int'(dropA), 0);
        checkOutput("reset_strob", 0, int'(strobA), 0);
        checkOutput("reset_data_out", 0, int'(dataA), 0);
        checkOutput("reset_strob", 1, int'(strobB), 0);
        repeat (2) @(negedge CLK);
        #1;
        resetModel();
        CLR_n = 1'b1;

        // Directed: A5 transfer, two ignored requests, then 3C in the done cycle.
        applyStimulus(1'b1, 8'hA5);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b1, 8'h11);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b1, 8'h22);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b1, 8'h3C);
        repeat (20) applyStimulus(1'b0, 8'h00);

        // Reset during the strobe: everything drops at once and no done is issued.
        applyStimulus(1'b1, 8'h5A);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00);
        #2;
        CLR_n = 1'b0;
        #1;
        checkOutput("async_reset_strob", 0, int'(strobA), 0);
        checkOutput("async_reset_busy", 0, int'(busyA), 0);
        checkOutput("async_reset_data_out", 0, int'(dataA), 0);
        checkOutput("async_reset_strob", 1, int'(strobB), 0);
        checkOutput("async_reset_busy", 1, int'(busyB), 0);
        repeat (2) @(negedge CLK);
        #1;
        resetModel();
        CLR_n = 1'b1;
        applyStimulus(1'b1, 8'hC3);
        repeat (20) applyStimulus(1'b0, 8'h00);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) applyStimulus(1'b1, 8'($urandom));
            else                           applyStimulus(1'b0, 8'h00);
        end
        repeat (30) applyStimulus(1'b0, 8'h00);

        checkOutput("pending_transfers", 0, expQ0.size(), 0);
        checkOutput("pending_transfers", 1, expQ1.size(), 0);
        checkOutput("pending_req_drops", 0, dropQ0.size(), 0);
        checkOutput("pending_req_drops", 1, dropQ1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
